pc_vec_irq: RTL and testbench



---
 rtl/pc_vec_irq_if.sv | 30 +++
 rtl/pc_vec_irq.sv | 123 ++++++++++++
 tb/tb_pc_vec_irq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_vec_irq_if.sv
// Program-counter / interrupt unit: CPU-side bus.
// Groups the control-unit request lines (writeBack, jump, offset, jump_addr, reti)
// and the PC/interrupt status returned to the CPU.
//   master : CPU control unit (drives requests, reads status)
//   slave  : pc_vec_irq (reads requests, drives status)
// LVL_W must equal $clog2(STACK_DEPTH+1) of the attached pc_vec_irq.
interface pc_vec_irq_if #(
  parameter int ADDR_W = 27,
  parameter int LVL_W  = 3
);
  logic              writeBack;
  logic              jump;
  logic              offset;
  logic [ADDR_W-1:0] jump_addr;
  logic              reti;
  logic [ADDR_W-1:0] pc_out;
  logic [7:0]        int_id;
  logic [LVL_W-1:0]  nest_level;
  logic              reti_underflow;

  modport master (
    output writeBack, jump, offset, jump_addr, reti,
    input  pc_out, int_id, nest_level, reti_underflow
  );

  modport slave (
    input  writeBack, jump, offset, jump_addr, reti,
    output pc_out, int_id, nest_level, reti_underflow
  );
endinterface

// File: rtl/pc_vec_irq.sv
// Program counter with N prioritised, maskable, edge-triggered interrupt channels,
// nested entry and a hardware return stack.
// All state changes happen on the falling clock edge; reset is asynchronous, active-low.
// Ports:
//   clk          clock (falling edge active)
//   reset_n      asynchronous active-low reset
//   bus          CPU-side bus (slave): writeBack/jump/offset/jump_addr/reti in,
//                pc_out/int_id/nest_level/reti_underflow out
//   int_in       interrupt request lines, rising-edge sensitive
//   int_mask     1 = channel enabled
//   int_pending  latched requests not yet taken
module pc_vec_irq #(
  parameter int                ADDR_W      = 27,
  parameter int                N_INT       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] PC_START    = 27'hC02422,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 27'd1,
  parameter logic [ADDR_W-1:0] PROT_LIMIT  = 27'hC02422
) (
  input  logic             clk,
  input  logic             reset_n,
  pc_vec_irq_if.slave      bus,
  input  logic [N_INT-1:0] int_in,
  input  logic [N_INT-1:0] int_mask,
  output logic [N_INT-1:0] int_pending
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  // Stack arrays are sized to the full index range of the level counter so the
  // level can index them directly; entries at or above STACK_DEPTH are never written.
  localparam int STK_N = 2 ** LVL_W;

  logic              wb_prev;
  logic [N_INT-1:0]  int_prev;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        id;
  logic [LVL_W-1:0]  lvl;
  logic [N_INT-1:0]  pend;
  logic              unf;
  logic [ADDR_W-1:0] stk_pc [STK_N];
  logic [7:0]        stk_id [STK_N];

  logic              step;
  logic [N_INT-1:0]  rise;
  logic [N_INT-1:0]  req;
  logic              found;
  logic [7:0]        w;
  logic              take;
  logic [N_INT-1:0]  take_bit;
  logic [ADDR_W-1:0] next_pc;

  assign step = bus.writeBack & ~wb_prev;
  assign rise = int_in & ~int_prev;
  assign req  = pend & int_mask;

  // Lowest-index request wins: scan downward so the last hit is the smallest index.
  always_comb begin
    found = 1'b0;
    w     = 8'd0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        w     = 8'(i);
      end
    end
  end

  // reti has priority over entry; nesting only preempts a lower-priority handler.
  assign take = step & ~bus.reti & found & (pc < PROT_LIMIT) &
                (lvl < LVL_W'(STACK_DEPTH)) & ((id == 8'hFF) | (w < id));

  assign take_bit = take ? (N_INT'(1) << w) : '0;

  assign next_pc = bus.jump ? (bus.offset ? pc + bus.jump_addr : bus.jump_addr)
                            : pc + ADDR_W'(1);

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_prev  <= 1'b0;
      int_prev <= '0;
      pc       <= PC_START;
      id       <= 8'hFF;
      lvl      <= '0;
      pend     <= '0;
      unf      <= 1'b0;
      for (int k = 0; k < STK_N; k++) begin
        stk_pc[k] <= '0;
        stk_id[k] <= 8'hFF;
      end
    end else begin
      wb_prev  <= bus.writeBack;
      int_prev <= int_in;
      // A new edge on the channel being taken re-arms it, so the event is not lost.
      pend     <= (pend & ~take_bit) | rise;
      if (step) begin
        unf <= 1'b0;
        if (bus.reti) begin
          if (lvl != '0) begin
            pc  <= stk_pc[lvl - LVL_W'(1)];
            id  <= stk_id[lvl - LVL_W'(1)];
            lvl <= lvl - LVL_W'(1);
          end else begin
            unf <= 1'b1;
            pc  <= pc + ADDR_W'(1);
          end
        end else if (take) begin
          stk_pc[lvl] <= next_pc;
          stk_id[lvl] <= id;
          pc          <= VEC_BASE + ADDR_W'(w);
          id          <= w;
          lvl         <= lvl + LVL_W'(1);
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

  assign bus.pc_out         = pc;
  assign bus.int_id         = id;
  assign bus.nest_level     = lvl;
  assign bus.reti_underflow = unf;
  assign int_pending        = pend;
endmodule

// File: tb/tb_pc_vec_irq.sv
module tb_pc_vec_irq;
  localparam logic [26:0] PC_START = 27'hC02422;
  localparam logic [26:0] VEC_BASE = 27'd1;
  localparam logic [26:0] PROT     = 27'hC02422;
  localparam int          DEPTH    = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] int_in;
  logic [7:0] int_mask;
  logic [7:0] int_pending;
  int         n_cmp;
  int         n_bad;

  pc_vec_irq_if #(.ADDR_W(27), .LVL_W(3)) bus ();

  pc_vec_irq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .int_in     (int_in),
    .int_mask   (int_mask),
    .int_pending(int_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural state with a queue as the return stack.
  typedef struct {
    logic [26:0] pc;
    logic [7:0]  id;
  } frame_t;

  logic [26:0] m_pc;
  logic [7:0]  m_id;
  logic [7:0]  m_pend;
  bit          m_unf;
  bit          m_wb_prev;
  logic [7:0]  m_int_prev;
  frame_t      m_stack[$];

  function automatic void model_reset();
    m_pc       = PC_START;
    m_id       = 8'hFF;
    m_pend     = 8'h00;
    m_unf      = 1'b0;
    m_wb_prev  = 1'b0;
    m_int_prev = 8'h00;
    m_stack.delete();
  endfunction

  function automatic void model_step();
    bit          stp;
    logic [7:0]  rise;
    logic [7:0]  req;
    int          win;
    bit          tk;
    logic [26:0] npc;
    frame_t      f;
    stp  = bus.writeBack && !m_wb_prev;
    rise = int_in & ~m_int_prev;
    req  = m_pend & int_mask;
    win  = -1;
    for (int i = 7; i >= 0; i--) if (req[i]) win = i;
    tk = stp && !bus.reti && (win >= 0) && (m_pc < PROT) &&
         (m_stack.size() < DEPTH) && ((m_id == 8'hFF) || (win < int'(m_id)));
    if (tk) m_pend[win] = 1'b0;
    m_pend = m_pend | rise;
    npc = bus.jump ? (bus.offset ? m_pc + bus.jump_addr : bus.jump_addr) : m_pc + 27'd1;
    if (stp) begin
      m_unf = 1'b0;
      if (bus.reti) begin
        if (m_stack.size() > 0) begin
          f    = m_stack.pop_back();
          m_pc = f.pc;
          m_id = f.id;
        end else begin
          m_unf = 1'b1;
          m_pc  = m_pc + 27'd1;
        end
      end else if (tk) begin
        f.pc = npc;
        f.id = m_id;
        m_stack.push_back(f);
        m_pc = VEC_BASE + 27'(win);
        m_id = 8'(win);
      end else begin
        m_pc = npc;
      end
    end
    m_wb_prev  = bus.writeBack;
    m_int_prev = int_in;
  endfunction

  // One clock: the model follows the DUT's falling edge; outputs are read at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset_n) model_step();
    else model_reset();
    @(posedge clk);
  endtask

  task automatic do_step(input bit j, input bit o, input logic [26:0] a, input bit r);
    bus.writeBack = 1'b1;
    bus.jump      = j;
    bus.offset    = o;
    bus.jump_addr = a;
    bus.reti      = r;
    tick();
    bus.writeBack = 1'b0;
    bus.jump      = 1'b0;
    bus.offset    = 1'b0;
    bus.reti      = 1'b0;
    tick();
  endtask

  task automatic pulse(input int ch);
    int_in[ch] = 1'b1;
    tick();
    int_in[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow} !==
        {PC_START, 8'hFF, 3'd0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got pc=%h id=%h lvl=%0d pend=%h unf=%b want pc=%h id=FF lvl=0 pend=00 unf=0",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow, PC_START);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      do_step(1'b0, 1'b0, 27'd0, 1'b0);
      n_cmp++;
      if ({bus.pc_out, bus.int_id} !== {PC_START + 27'(k), 8'hFF}) begin
        n_bad++;
        $display("FAIL seq_step%0d got pc=%h id=%h want pc=%h id=FF",
                 k, bus.pc_out, bus.int_id, PC_START + 27'(k));
      end
    end
  endtask

  task automatic test_irq_entry();
    int_mask = 8'hFF;
    do_step(1'b1, 1'b0, 27'd10, 1'b0);
    n_cmp++;
    if (bus.pc_out !== 27'd10) begin
      n_bad++;
      $display("FAIL abs_jump got pc=%h want 00000a", bus.pc_out);
    end
    pulse(3);
    n_cmp++;
    if (int_pending !== 8'h08) begin
      n_bad++;
      $display("FAIL pend_ch3 got %h want 08", int_pending);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending} !== {27'd4, 8'd3, 3'd1, 8'h00}) begin
      n_bad++;
      $display("FAIL entry_ch3 got pc=%h id=%h lvl=%0d pend=%h want pc=4 id=3 lvl=1 pend=00",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level} !== {27'd11, 8'hFF, 3'd0}) begin
      n_bad++;
      $display("FAIL reti_ch3 got pc=%h id=%h lvl=%0d want pc=b id=FF lvl=0",
               bus.pc_out, bus.int_id, bus.nest_level);
    end
  endtask

  task automatic test_nested();
    logic [26:0] exp_pc [7] = '{27'd6, 27'd3, 27'd3, 27'd4, 27'd7, 27'd12, 27'd7};
    logic [7:0]  exp_id [7] = '{8'd5, 8'd2, 8'd2, 8'd2, 8'd5, 8'hFF, 8'd6};
    logic [2:0]  exp_lv [7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd1};
    logic [7:0]  exp_pd [7] = '{8'h00, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: begin pulse(5); do_step(1'b0, 1'b0, 27'd0, 1'b0); end
        1: begin pulse(2); do_step(1'b0, 1'b0, 27'd0, 1'b0); end
        2: pulse(6);
        3: do_step(1'b0, 1'b0, 27'd0, 1'b0);
        4: do_step(1'b0, 1'b0, 27'd0, 1'b1);
        5: do_step(1'b0, 1'b0, 27'd0, 1'b1);
        default: do_step(1'b0, 1'b0, 27'd0, 1'b0);
      endcase
      n_cmp++;
      if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending} !==
          {exp_pc[s], exp_id[s], exp_lv[s], exp_pd[s]}) begin
        n_bad++;
        $display("FAIL nested_s%0d got pc=%h id=%h lvl=%0d pend=%h want pc=%h id=%h lvl=%0d pend=%h",
                 s, bus.pc_out, bus.int_id, bus.nest_level, int_pending,
                 exp_pc[s], exp_id[s], exp_lv[s], exp_pd[s]);
      end
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level} !== {27'd13, 8'hFF, 3'd0}) begin
      n_bad++;
      $display("FAIL nested_exit got pc=%h id=%h lvl=%0d want pc=d id=FF lvl=0",
               bus.pc_out, bus.int_id, bus.nest_level);
    end
  endtask

  task automatic test_mask();
    int_mask = 8'hFD;
    pulse(1);
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, int_pending} !== {27'd14, 8'hFF, 8'h02}) begin
      n_bad++;
      $display("FAIL masked_ch1 got pc=%h id=%h pend=%h want pc=e id=FF pend=02",
               bus.pc_out, bus.int_id, int_pending);
    end
    int_mask = 8'hFF;
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending} !== {27'd2, 8'd1, 3'd1, 8'h00}) begin
      n_bad++;
      $display("FAIL unmask_entry got pc=%h id=%h lvl=%0d pend=%h want pc=2 id=1 lvl=1 pend=00",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b1);
  endtask

  task automatic test_stack_full();
    for (int c = 7; c >= 4; c--) begin
      pulse(c);
      do_step(1'b0, 1'b0, 27'd0, 1'b0);
    end
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level} !== {27'd5, 8'd4, 3'd4}) begin
      n_bad++;
      $display("FAIL fill_stack got pc=%h id=%h lvl=%0d want pc=5 id=4 lvl=4",
               bus.pc_out, bus.int_id, bus.nest_level);
    end
    pulse(0);
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending} !== {27'd6, 8'd4, 3'd4, 8'h01}) begin
      n_bad++;
      $display("FAIL full_blocks got pc=%h id=%h lvl=%0d pend=%h want pc=6 id=4 lvl=4 pend=01",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b1);
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending} !== {27'd1, 8'd0, 3'd4, 8'h00}) begin
      n_bad++;
      $display("FAIL late_take got pc=%h id=%h lvl=%0d pend=%h want pc=1 id=0 lvl=4 pend=00",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending);
    end
    for (int r = 0; r < 4; r++) do_step(1'b0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level} !== {27'd16, 8'hFF, 3'd0}) begin
      n_bad++;
      $display("FAIL unwind got pc=%h id=%h lvl=%0d want pc=10 id=FF lvl=0",
               bus.pc_out, bus.int_id, bus.nest_level);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b1);
    n_cmp++;
    if ({bus.pc_out, bus.reti_underflow, bus.nest_level} !== {27'd17, 1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL underflow got pc=%h unf=%b lvl=%0d want pc=11 unf=1 lvl=0",
               bus.pc_out, bus.reti_underflow, bus.nest_level);
    end
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.reti_underflow} !== {27'd18, 1'b0}) begin
      n_bad++;
      $display("FAIL underflow_clear got pc=%h unf=%b want pc=12 unf=0",
               bus.pc_out, bus.reti_underflow);
    end
  endtask

  task automatic test_rel_wrap_hold();
    do_step(1'b1, 1'b0, 27'h7FFFFFF, 1'b0);
    do_step(1'b1, 1'b1, 27'd2, 1'b0);
    n_cmp++;
    if (bus.pc_out !== 27'd1) begin
      n_bad++;
      $display("FAIL rel_wrap got pc=%h want 0000001", bus.pc_out);
    end
    bus.writeBack = 1'b1;
    repeat (5) tick();
    bus.writeBack = 1'b0;
    tick();
    n_cmp++;
    if (bus.pc_out !== 27'd2) begin
      n_bad++;
      $display("FAIL wb_hold got pc=%h want 0000002", bus.pc_out);
    end
  endtask

  task automatic test_reset_mid();
    pulse(2);
    do_step(1'b0, 1'b0, 27'd0, 1'b0);
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level} !== {27'd3, 8'd2, 3'd1}) begin
      n_bad++;
      $display("FAIL pre_reset_entry got pc=%h id=%h lvl=%0d want pc=3 id=2 lvl=1",
               bus.pc_out, bus.int_id, bus.nest_level);
    end
    int_in[4] = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow} !==
        {PC_START, 8'hFF, 3'd0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset got pc=%h id=%h lvl=%0d pend=%h unf=%b want pc=%h id=FF lvl=0 pend=00 unf=0",
               bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow, PC_START);
    end
    @(posedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (int_pending !== 8'h10) begin
      n_bad++;
      $display("FAIL held_across_reset got pend=%h want 10", int_pending);
    end
    int_in = 8'h00;
  endtask

  task automatic test_random();
    bit o;
    for (int c = 0; c < 600; c++) begin
      o             = 1'($urandom_range(0, 1));
      bus.writeBack = 1'($urandom_range(0, 1));
      bus.jump      = ($urandom_range(0, 3) == 0);
      bus.offset    = o;
      bus.jump_addr = o ? 27'($urandom_range(0, 40)) : 27'($urandom_range(0, 300));
      bus.reti      = ($urandom_range(0, 4) == 0);
      int_in        = 8'($urandom) & 8'($urandom) & 8'($urandom);
      int_mask      = 8'($urandom) | 8'($urandom);
      tick();
      n_cmp++;
      if ({bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow} !==
          {m_pc, m_id, 3'(m_stack.size()), m_pend, m_unf}) begin
        n_bad++;
        $display("FAIL random_c%0d got pc=%h id=%h lvl=%0d pend=%h unf=%b want pc=%h id=%h lvl=%0d pend=%h unf=%b",
                 c, bus.pc_out, bus.int_id, bus.nest_level, int_pending, bus.reti_underflow,
                 m_pc, m_id, m_stack.size(), m_pend, m_unf);
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.writeBack = 1'b0;
    bus.jump      = 1'b0;
    bus.offset    = 1'b0;
    bus.jump_addr = '0;
    bus.reti      = 1'b0;
    int_in        = 8'h00;
    int_mask      = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_sequential();
    test_irq_entry();
    test_nested();
    test_mask();
    test_stack_full();
    test_rel_wrap_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
